uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter that shares the single UART transmitter among `N_REQ` byte requesters. Each requester holds the transmitter for a whole message, bounded by `req_last`. The block sequences the transmitter one byte at a time with a start/done handshake. It sits between the byte producers (command responder, status reporter, loopback path) and the transmitter, and a watchdog recovers from a stalled transmitter or owner.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `DW`, 8: data byte width
- `CLK_PER`, 100_000_000: clock frequency in Hz
- `TIMEOUT_US`, 2000: watchdog limit in µs; `TO_CYC = CLK_PER/1_000_000*TIMEOUT_US`

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `req_valid`  in  N_REQ  requester i has a byte pending
- `req_data`  in  N_REQ*DW  byte of requester i at `[i*DW +: DW]`
- `req_last`  in  N_REQ  pending byte of requester i ends its message
- `req_ready`  out  N_REQ  one-hot; byte of requester i accepted this cycle
- `grant`  out  N_REQ  one-hot current owner; 0 when idle
- `tx_start`  out  1  one-cycle pulse; transmitter loads `tx_data`
- `tx_data`  out  DW  byte to send; stable from `tx_start` until the next accept
- `tx_done`  in  1  one-cycle pulse from the transmitter when the stop bit completes
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires

## Operation
- State machine: IDLE, ISSUE, WAIT. Internal state: owner index `g`, priority pointer `ptr` (0..N_REQ-1), `last_q`, and watchdog counter `wd`.
- IDLE:
  - If any `req_valid` is high, `g` becomes the first valid index at or after `ptr`, searching modulo N_REQ.
  - `grant` is set to one-hot(`g`). Next state is ISSUE.
- ISSUE:
  - `req_ready[g] = req_valid[g]`. This is combinational from the registered state and `g`; all other `req_ready` bits are 0.
  - On the accept cycle, `tx_data` takes `req_data[g]` and `last_q` takes `req_last[g]`. Next state is WAIT.
  - If `req_valid[g]` is low, the block stays in ISSUE and keeps the grant (message lock).
- WAIT:
  - `tx_start` is high in the first WAIT cycle only.
  - A `tx_done` in that same cycle is ignored.
  - On a later `tx_done`:
    - if `last_q` = 1: release, with `grant` = 0, `ptr` = (g+1) mod N_REQ, next state IDLE;
    - otherwise: next state ISSUE.
- `tx_done` is ignored in IDLE and ISSUE.
- Watchdog:
  - `wd` clears on every entry to ISSUE or WAIT and counts every cycle spent in ISSUE or WAIT.
  - When `wd` reaches TO_CYC-1 without a transition, `timeout_err` pulses for 1 cycle. The block then releases exactly as on a last byte (`ptr` = g+1) and goes to IDLE.
  - Counter width is `$clog2(TO_CYC)`.
- Requesters that are not granted see `req_ready` = 0 regardless of their `req_valid`. A requester must hold `req_valid`, `req_data` and `req_last` stable until accepted.

## Timing
- Reset values: `grant` = 0, `req_ready` = 0, `tx_start` = 0, `tx_data` = 0, `timeout_err` = 0; `ptr` = 0, `wd` = 0, state IDLE.
- Reset mid-operation clears everything immediately. An in-flight UART frame is not aborted by this block.
- First byte, with `req_valid` rising in cycle 0 while IDLE:
  - cycle 1: `grant` and `req_ready` are high;
  - cycle 2: `tx_start` is high and `tx_data` is valid.
- Continuing message, with `tx_done` in cycle k: ISSUE in k+1, `tx_start` in k+2 if the owner is valid.
- After a last byte, with `tx_done` in cycle k: IDLE in k+1, new `grant` in k+2, `tx_start` in k+3.
- After a timeout, with `timeout_err` in cycle t: IDLE in t+1.
- `grant` changes only on entry to IDLE→ISSUE or on release. It is never reassigned while a message is in progress.

## Test plan
- Single message: requester 2 sends 0xA5 then 0x3C (last), with `tx_done` 10 cycles after each `tx_start` -> `tx_data` is 0xA5 then 0x3C, `grant` = 4'b0100 throughout, `ptr` = 3 after release, `timeout_err` = 0.
- Round robin: all four requesters valid with single-byte messages (last = 1) 0x10..0x13, starting from `ptr` = 0 -> `tx_data` order 0x10, 0x11, 0x12, 0x13. Re-asserting requester 0 afterwards is served next.
- Message lock: requester 0 sends a 3-byte message while requester 1 is valid throughout -> all 3 bytes of requester 0 go out contiguously, and `req_ready[1]` stays 0 until requester 0 is released.
- Transmitter stall: CLK_PER = 1_000_000, TIMEOUT_US = 50 (TO_CYC = 50), `tx_done` never asserted -> `timeout_err` pulses 49 cycles after WAIT entry, `grant` goes to 0, and the next valid requester is granted 2 cycles later.
- Owner stall: requester 1 sends a non-last byte then drops `req_valid` -> the block holds the grant in ISSUE, `timeout_err` pulses after TO_CYC cycles, and `ptr` = 2.
- Async reset mid-WAIT with `tx_start` already issued -> all outputs are 0 within the reset cycle, and after reset release a valid requester 3 is granted per the IDLE rules with `ptr` = 0.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: bundle of the requester byte bus and the transmitter
// handshake that the arbiter sits between.
//   req_valid/req_data/req_last : per-requester pending byte, lane i at [i*DW +: DW]
//   req_ready                   : one-hot accept strobe back to the requesters
//   grant                       : one-hot current owner, 0 when idle
//   tx_start/tx_data/tx_done    : byte handshake with the UART transmitter
//   timeout_err                 : watchdog pulse
// slave  = arbiter side, master = producer/transmitter side.
interface uart_tx_arb_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_last;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    grant;
    logic                tx_start;
    logic [DW-1:0]       tx_data;
    logic                tx_done;
    logic                timeout_err;

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, grant, tx_start, tx_data, timeout_err
    );

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, grant, tx_start, tx_data, timeout_err
    );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART transmitter among N_REQ
// byte producers. An owner keeps the transmitter for a whole message (up to
// the byte flagged req_last); bytes go out one at a time via tx_start/tx_done.
// A watchdog releases the owner if the transmitter or the owner stalls.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_tx_arb_if.slave (requester bus + transmitter handshake)
module uart_tx_arb #(
    parameter int N_REQ      = 4,
    parameter int DW         = 8,
    parameter int CLK_PER    = 100_000_000,
    parameter int TIMEOUT_US = 2000
) (
    input logic          clk,
    input logic          rst,
    uart_tx_arb_if.slave bus
);
    localparam int TO_CYC = CLK_PER / 1_000_000 * TIMEOUT_US;
    localparam int WD_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam int GW     = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                   state_q, state_d;
    logic [GW-1:0]            g_q, g_d;
    logic [GW-1:0]            ptr_q, ptr_d;
    logic                     last_q, last_d;
    logic [WD_W-1:0]          wd_q, wd_d;
    logic [N_REQ-1:0]         grant_q, grant_d;
    logic                     tx_start_q, tx_start_d;
    logic [DW-1:0]            tx_data_q, tx_data_d;

    logic [N_REQ-1:0][DW-1:0] lane_data;
    logic [GW-1:0]            cand;
    logic                     pick_vld;
    logic [GW-1:0]            pick_idx;
    logic [N_REQ-1:0]         req_ready;
    logic                     timeout_err;
    logic                     rel;
    logic                     wd_hit;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane_data[i] = bus.req_data[i*DW +: DW];
    end

    // First valid requester at or after ptr, modulo N_REQ. Scanning the
    // offsets from high to low lets the smallest offset win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = GW'((int'(ptr_q) + k) % N_REQ);
            if (bus.req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign wd_hit = (wd_q == WD_W'(TO_CYC - 1));

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        grant_d     = grant_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        wd_d        = wd_q + 1'b1;
        req_ready   = '0;
        timeout_err = 1'b0;
        rel         = 1'b0;

        case (state_q)
            S_IDLE: begin
                wd_d = '0;
                if (pick_vld) begin
                    g_d               = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Owner keeps the grant even while its valid is low, so a
                // message is never interleaved with another requester's.
                req_ready[g_q] = bus.req_valid[g_q];
                if (bus.req_valid[g_q]) begin
                    tx_data_d  = lane_data[g_q];
                    last_d     = bus.req_last[g_q];
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT;
                    wd_d       = '0;
                end else if (wd_hit) begin
                    timeout_err = 1'b1;
                    rel         = 1'b1;
                end
            end
            S_WAIT: begin
                // A done coincident with our own start pulse belongs to a
                // previous frame, not this byte.
                if (bus.tx_done && !tx_start_q) begin
                    if (last_q) begin
                        rel = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        wd_d    = '0;
                    end
                end else if (wd_hit) begin
                    timeout_err = 1'b1;
                    rel         = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                wd_d    = '0;
            end
        endcase

        // Release after a last byte or a watchdog expiry: hand priority to
        // the requester after the current owner.
        if (rel) begin
            grant_d = '0;
            ptr_d   = (g_q == GW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
            state_d = S_IDLE;
            wd_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            g_q        <= '0;
            ptr_q      <= '0;
            last_q     <= 1'b0;
            wd_q       <= '0;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            wd_q       <= wd_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.grant       = grant_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scenario tasks for uart_tx_arb with a byte scoreboard.
// Expected bytes (owner, data) are queued when a requester presents them and
// checked in order whenever tx_start fires. A simple transmitter model
// answers each tx_start with tx_done a fixed delay later when enabled.
module tb_uart_tx_arb;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.N_REQ(N), .DW(DW)) bus ();

    uart_tx_arb #(
        .N_REQ(N), .DW(DW), .CLK_PER(1_000_000), .TIMEOUT_US(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int         idx;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   to_cnt = 0;
    bit   tx_auto = 1'b1;
    int   tx_dly = 10;

    // Transmitter model: tx_done lands tx_dly cycles after the tx_start cycle.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start && tx_auto && !rst) begin
                repeat (tx_dly) @(negedge clk);
                bus.tx_done = 1'b1;
                @(negedge clk);
                bus.tx_done = 1'b0;
            end
        end
    end

    // Scoreboard consumer and per-cycle ready/grant consistency.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((bus.req_ready & ~bus.grant) != '0) begin
                errors++;
                $display("FAIL ready_outside_grant: req_ready=%b grant=%b", bus.req_ready, bus.grant);
            end
            if (bus.timeout_err) to_cnt++;
            if (bus.tx_start) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: tx_start with tx_data=%h, nothing expected", bus.tx_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.tx_data !== mon_e.d || bus.grant !== 4'(1 << mon_e.idx)) begin
                        errors++;
                        $display("FAIL sb_byte: got data=%h grant=%b, expected data=%h grant=%b",
                                 bus.tx_data, bus.grant, mon_e.d, 4'(1 << mon_e.idx));
                    end
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    task automatic drive(int i, logic [7:0] d, logic l);
        bus.req_valid[i]           = 1'b1;
        bus.req_data[i*DW +: DW]   = d;
        bus.req_last[i]            = l;
    endtask

    task automatic expect_byte(int i, logic [7:0] d);
        exp_t e;
        e.idx = i;
        e.d   = d;
        sb.push_back(e);
    endtask

    task automatic present(int i, logic [7:0] d, logic l);
        drive(i, d, l);
        expect_byte(i, d);
    endtask

    // Returns just after the accepting edge (first WAIT cycle).
    task automatic wait_accept(int i);
        int c = 0;
        #1;
        while (!bus.req_ready[i] && c < 1000) begin
            @(negedge clk);
            #1;
            c++;
        end
        checks++;
        if (!bus.req_ready[i]) begin
            errors++;
            $display("FAIL accept_timeout req%0d: req_ready=0, expected 1", i);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((bus.grant != '0 || sb.size() != 0) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (bus.grant != '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout: grant=%b pending=%0d, expected 0/0", bus.grant, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.grant, bus.req_ready, bus.tx_start, bus.tx_data, bus.timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b ready=%b start=%b data=%h to=%b, expected all 0",
                     bus.grant, bus.req_ready, bus.tx_start, bus.tx_data, bus.timeout_err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0000 || dut.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle: grant=%b ptr=%0d, expected 0000/0", bus.grant, dut.ptr_q);
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < N; i++) present(i, 8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < N; i++) wait_accept(i);
        present(0, 8'h14, 1'b1);
        present(2, 8'h15, 1'b1);
        wait_accept(0);
        wait_accept(2);
        wait_idle();
        checks++;
        if (dut.ptr_q !== 2'd3) begin
            errors++;
            $display("FAIL rr_ptr: ptr=%0d, expected 3", dut.ptr_q);
        end
    endtask

    task automatic test_single();
        int c0;
        int cnt;
        int bad;
        @(negedge clk);
        c0 = to_cnt;
        present(2, 8'hA5, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0100 || bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: grant=%b ready=%b, expected 0100/0100", bus.grant, bus.req_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_first_start: start=%b data=%h, expected 1/a5", bus.tx_start, bus.tx_data);
        end
        present(2, 8'h3C, 1'b1);
        wait_accept(2);
        @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b1) begin
            errors++;
            $display("FAIL single_second_start: start=%b, expected 1", bus.tx_start);
        end
        cnt = 0;
        bad = 0;
        while (bus.grant != '0 && cnt < 200) begin
            if (bus.grant !== 4'b0100) bad++;
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != 11 || bad != 0) begin
            errors++;
            $display("FAIL single_release: cycles=%0d bad_grant=%0d, expected 11/0", cnt, bad);
        end
        checks++;
        if (dut.ptr_q !== 2'd3 || to_cnt != c0) begin
            errors++;
            $display("FAIL single_ptr: ptr=%0d timeouts=%0d, expected 3/0", dut.ptr_q, to_cnt - c0);
        end
    endtask

    task automatic test_lock();
        int viol = 0;
        int seen = 0;
        @(negedge clk);
        drive(1, 8'h30, 1'b1);
        fork
            begin
                present(0, 8'h20, 1'b0);
                wait_accept(0);
                present(0, 8'h21, 1'b0);
                wait_accept(0);
                present(0, 8'h22, 1'b1);
                wait_accept(0);
            end
            begin
                int c = 0;
                while (bus.grant != 4'b0001 && c < 100) begin
                    @(negedge clk);
                    c++;
                end
                while (bus.grant == 4'b0001 && c < 1000) begin
                    seen++;
                    if (bus.req_ready[1]) viol++;
                    @(negedge clk);
                    c++;
                end
            end
        join
        checks++;
        if (viol != 0 || seen == 0) begin
            errors++;
            $display("FAIL lock_ready1: ready1_cycles=%0d owner_cycles=%0d, expected 0/>0", viol, seen);
        end
        expect_byte(1, 8'h30);
        wait_accept(1);
        wait_idle();
    endtask

    task automatic test_tx_stall();
        int c0;
        int cnt;
        @(negedge clk);
        tx_auto = 1'b0;
        c0 = to_cnt;
        present(2, 8'h40, 1'b1);
        present(3, 8'h41, 1'b1);
        wait_accept(2);
        @(negedge clk);
        cnt = 0;
        while (!bus.timeout_err && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != 49) begin
            errors++;
            $display("FAIL stall_timeout_latency: cycles=%0d, expected 49", cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0000) begin
            errors++;
            $display("FAIL stall_release: grant=%b, expected 0000", bus.grant);
        end
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b1000) begin
            errors++;
            $display("FAIL stall_next_grant: grant=%b, expected 1000", bus.grant);
        end
        tx_auto = 1'b1;
        wait_accept(3);
        wait_idle();
        checks++;
        if (to_cnt - c0 != 1) begin
            errors++;
            $display("FAIL stall_pulses: timeout pulses=%0d, expected 1", to_cnt - c0);
        end
    endtask

    task automatic test_owner_stall();
        int cnt;
        @(negedge clk);
        present(1, 8'h50, 1'b0);
        wait_accept(1);
        @(negedge clk);
        cnt = 0;
        while (!bus.timeout_err && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != 60 || bus.grant !== 4'b0010) begin
            errors++;
            $display("FAIL owner_stall_timeout: cycles=%0d grant=%b, expected 60/0010", cnt, bus.grant);
        end
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0000 || dut.ptr_q !== 2'd2) begin
            errors++;
            $display("FAIL owner_stall_release: grant=%b ptr=%0d, expected 0000/2", bus.grant, dut.ptr_q);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        tx_auto = 1'b0;
        present(2, 8'h70, 1'b1);
        wait_accept(2);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.grant, bus.req_ready, bus.tx_start, bus.tx_data, bus.timeout_err} !== '0
            || dut.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: grant=%b ready=%b start=%b data=%h to=%b ptr=%0d, expected all 0",
                     bus.grant, bus.req_ready, bus.tx_start, bus.tx_data, bus.timeout_err, dut.ptr_q);
        end
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        present(3, 8'h71, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b1000) begin
            errors++;
            $display("FAIL reset_mid_regrant: grant=%b, expected 1000", bus.grant);
        end
        tx_auto = 1'b1;
        wait_accept(3);
        wait_idle();
        checks++;
        if (dut.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_ptr: ptr=%0d, expected 0", dut.ptr_q);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_lock();
        test_tx_stall();
        test_owner_stall();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d bytes never sent, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
